// File: rtl/pmem_rr_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// One cacheline transaction at a time; includes a sticky watchdog for stalled memory.
module pmem_rr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              pmem_err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  state_t             state_nxt;
  logic               grant_i;
  logic               grant_d;
  logic               last_grant_d;
  logic               d_op_wr;
  logic [CNT_W-1:0]   wd_cnt;
  logic               busy;

  // Handshake: each cache holds its request until its one-cycle resp; memory
  // sees a strobe held until pmem_resp, which is only honoured while BUSY.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_read && (d_read || d_write)) begin
          grant_i = last_grant_d;
          grant_d = !last_grant_d;
        end else begin
          grant_i = i_read;
          grant_d = d_read || d_write;
        end
        if (grant_i)      state_nxt = BUSY_I;
        else if (grant_d) state_nxt = BUSY_D;
      end
      BUSY_I:  if (pmem_resp) state_nxt = DONE_I;
      BUSY_D:  if (pmem_resp) state_nxt = DONE_D;
      DONE_I:  state_nxt = IDLE;
      DONE_D:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      d_op_wr      <= 1'b0;
      pmem_addr    <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      wd_cnt       <= '0;
      pmem_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_i || grant_d) begin
        last_grant_d <= grant_d;
        pmem_addr    <= grant_d ? d_addr : i_addr;
        wd_cnt       <= '0;
      end
      // d_write dominates the illegal read+write combination.
      if (grant_d) begin
        pmem_wdata <= d_wdata;
        d_op_wr    <= d_write;
      end
      if (busy) begin
        if (pmem_resp) begin
          if (state == BUSY_I)  i_rdata <= pmem_rdata;
          else if (!d_op_wr)    d_rdata <= pmem_rdata;
        end else if (wd_cnt != CNT_W'(TIMEOUT)) begin
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_cnt == CNT_W'(TIMEOUT - 1)) pmem_err <= 1'b1;
        end
      end
    end
  end

  // Outputs decode straight from flops, so reset drops the strobes immediately.
  assign pmem_read  = (state == BUSY_I) || ((state == BUSY_D) && !d_op_wr);
  assign pmem_write = (state == BUSY_D) && d_op_wr;
  assign i_resp     = (state == DONE_I);
  assign d_resp     = (state == DONE_D);
  assign dbg_state  = state;

endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// Scoreboard bench for pmem_rr_arbiter: randomized rounds checked against a
// queue-based round-robin model, plus directed watchdog, spurious and reset cases.
module tb_pmem_rr_arbiter;
  localparam int AW       = 32;
  localparam int LW       = 256;
  localparam int TO       = 32;
  localparam int WAIT_MAX = 400;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          pmem_err;
  logic [2:0]    dbg_state;

  pmem_rr_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .pmem_err(pmem_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_last_d;
  logic [LW-1:0] m_i_rdata;
  logic [LW-1:0] m_d_rdata;
  bit          m_err;

  // {err, side, i_rdata, d_rdata}
  logic [2*LW+1:0]  exp_resp_q[$];
  // {lat[15:0], write, addr, wdata}
  logic [LW+AW+16:0] exp_pmem_q[$];
  int                lat_q[$];
  bit                spur_req = 1'b0;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (a == 32'h0000_1000) return {32{8'hA5}};
    return {a, ~a, {6{a ^ 32'h9E37_79B9}}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    return a & 32'hFFFF_FFE0;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last_d  = 1'b1;
    m_i_rdata = '0;
    m_d_rdata = '0;
    m_err     = 1'b0;
  endtask

  task automatic push_i(input logic [AW-1:0] a, input int lat);
    m_last_d  = 1'b0;
    m_i_rdata = line_of(a);
    m_err     = m_err | (lat > TO);
    exp_pmem_q.push_back({16'(lat), 1'b0, a, {LW{1'b0}}});
    exp_resp_q.push_back({m_err, 1'b0, m_i_rdata, m_d_rdata});
    lat_q.push_back(lat);
  endtask

  task automatic push_d(input logic [AW-1:0] a, input logic [LW-1:0] wd, input bit wr, input int lat);
    m_last_d = 1'b1;
    if (!wr) m_d_rdata = line_of(a);
    m_err = m_err | (lat > TO);
    exp_pmem_q.push_back({16'(lat), wr, a, wd});
    exp_resp_q.push_back({m_err, 1'b1, m_i_rdata, m_d_rdata});
    lat_q.push_back(lat);
  endtask

  // driver tasks
  task automatic wait_side(input bit side);
    int  n   = 0;
    bit  got = 1'b0;
    while (!got && n < WAIT_MAX) begin
      @(negedge clk);
      got = side ? d_resp : i_resp;
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: side %0d got no resp within %0d cycles", side, WAIT_MAX);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_i(input logic [AW-1:0] a, input bit mutate);
    i_read = 1'b1;
    i_addr = a;
    if (mutate) begin
      @(posedge clk); #1;
      i_addr = a ^ 32'h40;
    end
    wait_side(1'b0);
    i_read = 1'b0;
  endtask

  task automatic drive_d(input logic [AW-1:0] a, input logic [LW-1:0] wd,
                         input bit rd, input bit wr, input bit mutate);
    d_read  = rd;
    d_write = wr;
    d_addr  = a;
    d_wdata = wd;
    if (mutate) begin
      @(posedge clk); #1;
      d_addr  = a ^ 32'h40;
      d_wdata = ~wd;
    end
    wait_side(1'b1);
    d_read  = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic do_round(input bit use_i, input bit d_rd, input bit d_wr,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [LW-1:0] wd, input int li, input int ld);
    bit use_d;
    bit i_first;
    use_d   = d_rd || d_wr;
    i_first = (use_i && use_d) ? m_last_d : use_i;
    if (use_i && i_first)  push_i(ia, li);
    if (use_d)             push_d(da, wd, d_wr, ld);
    if (use_i && !i_first) push_i(ia, li);
    fork
      begin if (use_i) drive_i(ia, i_first); end
      begin if (use_d) drive_d(da, wd, d_rd, d_wr, !i_first); end
    join
  endtask

  // memory responder
  initial begin
    bit active = 1'b0;
    int cnt    = 0;
    int cur    = 1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (spur_req) begin
        spur_req   = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
      end else if (rst && (pmem_read || pmem_write)) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          cur    = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        end
        cnt++;
        if (cnt >= cur) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_read ? line_of(pmem_addr) : rand_line();
          active     = 1'b0;
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    bit                prev_resp = 1'b0;
    int                run       = 0;
    logic [2*LW+1:0]   r;
    logic [LW+AW+16:0] p;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_resp = 1'b0;
        run       = 0;
      end else begin
        checks++;
        if ((pmem_read && pmem_write) || (i_resp && d_resp) ||
            ((i_resp || d_resp) && (pmem_read || pmem_write)) ||
            (prev_resp && (i_resp || d_resp))) begin
          errors++;
          $display("FAIL invariant: rd=%0b wr=%0b i_resp=%0b d_resp=%0b prev_resp=%0b",
                   pmem_read, pmem_write, i_resp, d_resp, prev_resp);
        end
        if (pmem_read || pmem_write) run++;
        else run = 0;
        if (pmem_resp && (pmem_read || pmem_write)) begin
          if (exp_pmem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pmem_unexpected: txn at addr %0h with nothing expected", pmem_addr);
          end else begin
            p = exp_pmem_q.pop_front();
            chk("pmem_write_op", LW'(pmem_write), LW'(p[LW+AW]));
            chk("pmem_read_op", LW'(pmem_read), LW'(!p[LW+AW]));
            chk("pmem_addr", LW'(pmem_addr), LW'(p[LW+AW-1:LW]));
            if (p[LW+AW]) chk("pmem_wdata", pmem_wdata, p[LW-1:0]);
            chk("strobe_cycles", LW'(run), LW'(p[LW+AW+16:LW+AW+1]));
          end
        end
        if (i_resp || d_resp) begin
          if (exp_resp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: i_resp=%0b d_resp=%0b with nothing expected", i_resp, d_resp);
          end else begin
            r = exp_resp_q.pop_front();
            chk("resp_side", LW'(d_resp), LW'(r[2*LW]));
            chk("i_rdata", i_rdata, r[2*LW-1:LW]);
            chk("d_rdata", d_rdata, r[LW-1:0]);
            chk("pmem_err_at_resp", LW'(pmem_err), LW'(r[2*LW+1]));
          end
        end
        prev_resp = i_resp || d_resp;
      end
    end
  end

  task automatic watch_wd();
    int k    = 0;
    int n    = 0;
    bit done = 1'b0;
    while (!done && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
      if (pmem_read) begin
        k++;
        if (k == TO) chk("wd_err_before_limit", LW'(pmem_err), LW'(0));
        if (k == TO + 1) begin
          chk("wd_err_at_limit", LW'(pmem_err), LW'(1));
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wd_watch_timeout: strobe held %0d of %0d cycles", k, TO + 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pmem_read"}, LW'(pmem_read), LW'(0));
    chk({tag, "_pmem_write"}, LW'(pmem_write), LW'(0));
    chk({tag, "_resps"}, LW'({i_resp, d_resp}), LW'(0));
    chk({tag, "_pmem_addr"}, LW'(pmem_addr), LW'(0));
    chk({tag, "_pmem_wdata"}, pmem_wdata, '0);
    chk({tag, "_i_rdata"}, i_rdata, '0);
    chk({tag, "_d_rdata"}, d_rdata, '0);
    chk({tag, "_pmem_err"}, LW'(pmem_err), LW'(0));
  endtask

  // main stimulus
  initial begin
    bit   use_i, d_rd, d_wr;
    int   sel;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // ties from reset: I first, then D; a repeat tie goes to I again
    do_round(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_5000, '0, 2, 3);
    do_round(1'b1, 1'b1, 1'b0, 32'h0000_4020, 32'h0000_5020, '0, 1, 1);

    // I read alone, 5-cycle memory
    do_round(1'b1, 1'b0, 1'b0, 32'h0000_1000, '0, '0, 5, 1);

    // D write with inputs changed during BUSY
    do_round(1'b0, 1'b0, 1'b1, '0, 32'h0000_2000, {8{32'h1234_5678}}, 1, 3);

    // illegal read+write: write wins
    do_round(1'b0, 1'b1, 1'b1, '0, 32'h0000_2040, rand_line(), 1, 2);

    // spurious pmem_resp in IDLE
    @(negedge clk); spur_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_i_rdata", i_rdata, m_i_rdata);
    chk("spur_d_rdata", d_rdata, m_d_rdata);
    chk("spur_strobes", LW'({pmem_read, pmem_write}), LW'(0));

    for (int r = 0; r < 40; r++) begin
      sel   = $urandom_range(1, 3);
      use_i = sel[0];
      d_rd  = 1'b0;
      d_wr  = 1'b0;
      if (sel[1]) begin
        d_wr = $urandom_range(0, 1);
        d_rd = !d_wr || ($urandom_range(0, 7) == 0);
      end
      do_round(use_i, d_rd, d_wr, rand_addr(), rand_addr(), rand_line(),
               $urandom_range(1, 6), $urandom_range(1, 6));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // watchdog boundary: TO-cycle memory is fine, TO+1 trips it
    do_round(1'b1, 1'b0, 1'b0, 32'h0000_6000, '0, '0, TO, 1);
    fork
      do_round(1'b1, 1'b0, 1'b0, 32'h0000_6020, '0, '0, TO + 1, 1);
      watch_wd();
    join
    do_round(1'b1, 1'b1, 1'b1, 32'h0000_6040, 32'h0000_6060, rand_line(), 2, 2);

    // reset mid BUSY_D
    lat_q.push_back(1000);
    d_read = 1'b1; d_write = 1'b0; d_addr = 32'h0000_3000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_strobe", LW'(pmem_read), LW'(1));
    d_read = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk); rst = 1'b1;
    model_reset();
    lat_q.delete();
    @(negedge clk); spur_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("late_resp_i_rdata", i_rdata, '0);
    chk("late_resp_d_rdata", d_rdata, '0);
    do_round(1'b1, 1'b1, 1'b0, 32'h0000_7000, 32'h0000_7020, '0, 1, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("resp_q_drained", LW'(exp_resp_q.size()), LW'(0));
    chk("pmem_q_drained", LW'(exp_pmem_q.size()), LW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
